// File: rtl/invader_formation.sv
// rtl/invader_formation.sv - ROWS x COLS invader formation: step-timed march, wall descent, per-row bullet hits, landed/cleared end states
module invader_formation #(
    parameter int COLS            = 20,
    parameter int ROWS            = 3,
    parameter int INIT_WIDTH      = 9,
    parameter int LAND_LINE       = 13,
    parameter int STEP_CYCLES     = 3600000,
    parameter int SPEEDUP_CYCLES  = 20000,
    parameter int MIN_STEP_CYCLES = 360000,
    localparam int XW = $clog2(COLS),
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 i_clk_36MHz,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_bullet_valid,
    input  logic [XW-1:0]        i_bullet_x,
    input  logic [3:0]           i_bullet_y,
    output logic                 o_hit,
    output logic [XW-1:0]        o_hit_x,
    output logic [RW-1:0]        o_hit_row,
    output logic [ROWS*COLS-1:0] o_invaders_array,
    output logic [3:0]           o_invaders_line,
    output logic                 o_step,
    output logic                 o_landed,
    output logic                 o_cleared
);

    localparam int KW = $clog2(ROWS*COLS + 1);
    localparam int CW = $clog2(STEP_CYCLES + 1);
    localparam logic [COLS-1:0] INIT_ROW = COLS'((64'd1 << INIT_WIDTH) - 64'd1);

    typedef enum logic [1:0] {S_IDLE, S_MARCH, S_LANDED, S_CLEARED} state_t;

    state_t                state, state_n;
    logic [ROWS*COLS-1:0]  rows, rows_n;
    logic [3:0]            line, line_n;
    logic                  dir_right, dir_right_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [KW-1:0]         killed, killed_n;
    logic                  hit, hit_n;
    logic [XW-1:0]         hit_x, hit_x_n;
    logic [RW-1:0]         hit_row, hit_row_n;
    logic                  step, step_n;

    logic [31:0]           reduction, period;
    logic                  step_due;
    logic                  hit_any;
    logic [XW-1:0]         hit_col_sel;
    logic [RW-1:0]         hit_row_sel;
    logic [ROWS*COLS-1:0]  kill_mask, rows_hit, rows_shl, rows_shr;
    logic                  at_left, at_right;
    logic [RW-1:0]         top_row;
    logic [5:0]            land_sum;

    // Period shrinks with kills; saturates at the floor instead of underflowing.
    always_comb begin
        reduction = 32'(killed) * 32'(SPEEDUP_CYCLES);
        if (reduction + 32'(MIN_STEP_CYCLES) >= 32'(STEP_CYCLES))
            period = 32'(MIN_STEP_CYCLES);
        else
            period = 32'(STEP_CYCLES) - reduction;
        step_due = (32'(cnt) + 32'd1 >= period);
    end

    always_comb begin
        hit_any     = 1'b0;
        hit_col_sel = '0;
        hit_row_sel = '0;
        kill_mask   = '0;
        at_left     = 1'b0;
        at_right    = 1'b0;
        top_row     = '0;
        rows_shl    = '0;
        rows_shr    = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (i_bullet_valid && ({1'b0, i_bullet_y} == 5'(line) + 5'(r + 1)) &&
                    (i_bullet_x == XW'(c)) && rows[r*COLS + c]) begin
                    hit_any             = 1'b1;
                    hit_col_sel         = XW'(c);
                    hit_row_sel         = RW'(r);
                    kill_mask[r*COLS+c] = 1'b1;
                end
            end
            at_left  = at_left  | rows[r*COLS + COLS - 1];
            at_right = at_right | rows[r*COLS];
            if (|rows[r*COLS +: COLS])
                top_row = RW'(r);
            rows_shl[r*COLS +: COLS] = {rows[r*COLS +: COLS-1], 1'b0};
            rows_shr[r*COLS +: COLS] = {1'b0, rows[r*COLS+1 +: COLS-1]};
        end
        rows_hit = rows & ~kill_mask;
        land_sum = 6'(line) + 6'd1 + 6'(top_row);
    end

    always_comb begin
        state_n     = state;
        rows_n      = rows;
        line_n      = line;
        dir_right_n = dir_right;
        cnt_n       = cnt;
        killed_n    = killed;
        hit_n       = 1'b0;
        hit_x_n     = hit_x;
        hit_row_n   = hit_row;
        step_n      = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_n = S_MARCH;
                    cnt_n   = '0;
                end
            end
            S_MARCH: begin
                if (hit_any) begin
                    // A hit wins over a due step; the step retries next cycle.
                    rows_n    = rows_hit;
                    if (killed != {KW{1'b1}})
                        killed_n = killed + KW'(1);
                    hit_n     = 1'b1;
                    hit_x_n   = hit_col_sel;
                    hit_row_n = hit_row_sel;
                    if (!step_due)
                        cnt_n = cnt + CW'(1);
                    if (rows_hit == '0)
                        state_n = S_CLEARED;
                end else if (step_due) begin
                    cnt_n  = '0;
                    step_n = 1'b1;
                    if ((!dir_right && at_left) || (dir_right && at_right)) begin
                        line_n      = line + 4'd1;
                        dir_right_n = ~dir_right;
                        if (land_sum >= 6'(LAND_LINE))
                            state_n = S_LANDED;
                    end else begin
                        rows_n = dir_right ? rows_shr : rows_shl;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk_36MHz) begin
        if (!i_reset) begin
            state     <= S_IDLE;
            rows      <= {ROWS{INIT_ROW}};
            line      <= 4'd1;
            dir_right <= 1'b0;
            cnt       <= '0;
            killed    <= '0;
            hit       <= 1'b0;
            hit_x     <= '0;
            hit_row   <= '0;
            step      <= 1'b0;
        end else begin
            state     <= state_n;
            rows      <= rows_n;
            line      <= line_n;
            dir_right <= dir_right_n;
            cnt       <= cnt_n;
            killed    <= killed_n;
            hit       <= hit_n;
            hit_x     <= hit_x_n;
            hit_row   <= hit_row_n;
            step      <= step_n;
        end
    end

    assign o_hit            = hit;
    assign o_hit_x          = hit_x;
    assign o_hit_row        = hit_row;
    assign o_invaders_array = rows;
    assign o_invaders_line  = line;
    assign o_step           = step;
    assign o_landed         = (state == S_LANDED);
    assign o_cleared        = (state == S_CLEARED);

endmodule

// File: tb/tb_invader_formation.sv
// tb/tb_invader_formation.sv - self-checking bench for invader_formation with a short step period
module tb_invader_formation;

    localparam int COLS = 20;
    localparam int ROWS = 3;
    localparam int XW   = 5;
    localparam int RW   = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 bv;
    logic [XW-1:0]        bx;
    logic [3:0]           by;
    logic                 o_hit;
    logic [XW-1:0]        o_hit_x;
    logic [RW-1:0]        o_hit_row;
    logic [ROWS*COLS-1:0] o_arr;
    logic [3:0]           o_line;
    logic                 o_step;
    logic                 o_landed;
    logic                 o_cleared;

    invader_formation #(
        .STEP_CYCLES    (10),
        .SPEEDUP_CYCLES (2),
        .MIN_STEP_CYCLES(4)
    ) dut (
        .i_clk_36MHz     (clk),
        .i_reset         (rst_n),
        .i_start         (start),
        .i_bullet_valid  (bv),
        .i_bullet_x      (bx),
        .i_bullet_y      (by),
        .o_hit           (o_hit),
        .o_hit_x         (o_hit_x),
        .o_hit_row       (o_hit_row),
        .o_invaders_array(o_arr),
        .o_invaders_line (o_line),
        .o_step          (o_step),
        .o_landed        (o_landed),
        .o_cleared       (o_cleared)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XW-1:0] x;
        logic [RW-1:0] row;
    } hit_t;

    typedef struct {
        logic          fire;
        logic [XW-1:0] bx;
        logic [3:0]    by;
        logic [RW-1:0] hrow;
        int            ivl;
        logic          chk;
        logic [COLS-1:0] rowpat;
        logic [3:0]    line;
    } vec_t;

    hit_t sb_q[$];
    vec_t tbl[19];
    int   errors = 0;
    int   checks = 0;
    int   steps  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (o_step) steps++;
        if (o_hit) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hit: got x=%0d row=%0d expected no hit", o_hit_x, o_hit_row);
            end else begin
                hit_t e;
                e = sb_q.pop_front();
                check("hit_x", 64'(o_hit_x), 64'(e.x));
                check("hit_row", 64'(o_hit_row), 64'(e.row));
            end
        end
    endtask

    task automatic do_reset();
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        rst_n = 1'b0;
        start = 1'b0;
        bv    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fire(input int x, input int y, input logic exp_hit, input int row);
        hit_t e;
        bv = 1'b1;
        bx = XW'(x);
        by = 4'(y);
        if (exp_hit) begin
            e.x   = XW'(x);
            e.row = RW'(row);
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            tick();
            n++;
            bv = 1'b0;
        end while (!o_step && n < 200);
    endtask

    localparam logic [59:0] INIT_ARR = {20'h001FF, 20'h001FF, 20'h001FF};

    initial begin
        int n;
        int s0;
        rst_n = 1'b0; start = 1'b0; bv = 1'b0; bx = '0; by = '0;

        tbl[0]  = '{1'b0, 5'd0,  4'd0, 2'd0, 10, 1'b1, 20'h003FE, 4'd1};
        tbl[1]  = '{1'b0, 5'd0,  4'd0, 2'd0, 10, 1'b1, 20'h007FC, 4'd1};
        tbl[2]  = '{1'b0, 5'd0,  4'd0, 2'd0, 10, 1'b1, 20'h00FF8, 4'd1};
        tbl[3]  = '{1'b0, 5'd0,  4'd0, 2'd0, 10, 1'b1, 20'h01FF0, 4'd1};
        tbl[4]  = '{1'b0, 5'd0,  4'd0, 2'd0, 10, 1'b1, 20'h03FE0, 4'd1};
        tbl[5]  = '{1'b0, 5'd0,  4'd0, 2'd0, 10, 1'b1, 20'h07FC0, 4'd1};
        tbl[6]  = '{1'b0, 5'd0,  4'd0, 2'd0, 10, 1'b1, 20'h0FF80, 4'd1};
        tbl[7]  = '{1'b0, 5'd0,  4'd0, 2'd0, 10, 1'b1, 20'h1FF00, 4'd1};
        tbl[8]  = '{1'b0, 5'd0,  4'd0, 2'd0, 10, 1'b1, 20'h3FE00, 4'd1};
        tbl[9]  = '{1'b0, 5'd0,  4'd0, 2'd0, 10, 1'b1, 20'h7FC00, 4'd1};
        tbl[10] = '{1'b0, 5'd0,  4'd0, 2'd0, 10, 1'b1, 20'hFF800, 4'd1};
        tbl[11] = '{1'b0, 5'd0,  4'd0, 2'd0, 10, 1'b1, 20'hFF800, 4'd2};
        tbl[12] = '{1'b0, 5'd0,  4'd0, 2'd0, 10, 1'b1, 20'h7FC00, 4'd2};
        tbl[13] = '{1'b0, 5'd0,  4'd0, 2'd0, 10, 1'b1, 20'h3FE00, 4'd2};
        tbl[14] = '{1'b1, 5'd13, 4'd3, 2'd0, 8,  1'b0, 20'h00000, 4'd2};
        tbl[15] = '{1'b1, 5'd13, 4'd4, 2'd1, 6,  1'b0, 20'h00000, 4'd2};
        tbl[16] = '{1'b1, 5'd13, 4'd5, 2'd2, 4,  1'b0, 20'h00000, 4'd2};
        tbl[17] = '{1'b1, 5'd11, 4'd3, 2'd0, 4,  1'b0, 20'h00000, 4'd2};
        tbl[18] = '{1'b1, 5'd5,  4'd3, 2'd0, 4,  1'b0, 20'h00000, 4'd2};

        // Reset state and frozen IDLE
        do_reset();
        check("reset_array", 64'(o_arr), 64'(INIT_ARR));
        check("reset_line", 64'(o_line), 64'd1);
        check("reset_hit", 64'(o_hit), 64'd0);
        check("reset_step", 64'(o_step), 64'd0);
        check("reset_landed", 64'(o_landed), 64'd0);
        check("reset_cleared", 64'(o_cleared), 64'd0);
        check("reset_hit_x", 64'(o_hit_x), 64'd0);
        check("reset_hit_row", 64'(o_hit_row), 64'd0);
        s0 = steps;
        fire(0, 2, 1'b0, 0);
        tick();
        bv = 1'b0;
        check("idle_no_hit", 64'(o_hit), 64'd0);
        repeat (99) tick();
        check("idle_no_steps", 64'(steps - s0), 64'd0);
        check("idle_array", 64'(o_arr), 64'(INIT_ARR));

        // March, wall descent, acceleration
        do_start();
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].fire) fire(int'(tbl[i].bx), int'(tbl[i].by), 1'b1, int'(tbl[i].hrow));
            wait_step(n);
            check($sformatf("interval_%0d", i), 64'(n), 64'(tbl[i].ivl));
            if (tbl[i].chk) begin
                check($sformatf("array_%0d", i), 64'(o_arr), 64'({3{tbl[i].rowpat}}));
                check($sformatf("line_%0d", i), 64'(o_line), 64'(tbl[i].line));
            end
        end
        check("accel_array", 64'(o_arr), 64'({20'h01BF0, 20'h01DF0, 20'h01CE0}));
        check("accel_line", 64'(o_line), 64'd2);

        // Per-row hits and non-hits
        do_reset();
        do_start();
        fire(0, 4, 1'b1, 2);
        tick();
        bv = 1'b0;
        check("hit_pulse", 64'(o_hit), 64'd1);
        tick();
        check("hit_one_cycle", 64'(o_hit), 64'd0);
        check("hit_cleared_bit", 64'(o_arr), 64'({20'h001FE, 20'h001FF, 20'h001FF}));
        fire(0, 4, 1'b0, 0);
        tick();
        check("repeat_no_hit", 64'(o_hit), 64'd0);
        fire(25, 2, 1'b0, 0);
        tick();
        check("x_oob_no_hit", 64'(o_hit), 64'd0);
        fire(0, 5, 1'b0, 0);
        tick();
        check("y_below_no_hit", 64'(o_hit), 64'd0);
        fire(1, 1, 1'b0, 0);
        tick();
        bv = 1'b0;
        check("y_above_no_hit", 64'(o_hit), 64'd0);
        check("hold_hit_x", 64'(o_hit_x), 64'd0);
        check("hold_hit_row", 64'(o_hit_row), 64'd2);
        check("no_hit_array", 64'(o_arr), 64'({20'h001FE, 20'h001FF, 20'h001FF}));
        fire(3, 2, 1'b1, 0);
        tick();
        bv = 1'b0;
        check("row0_array", 64'(o_arr), 64'({20'h001FE, 20'h001FF, 20'h001F7}));

        // Hit coincident with a step event
        do_reset();
        do_start();
        repeat (9) tick();
        fire(0, 2, 1'b1, 0);
        tick();
        bv = 1'b0;
        check("coinc_hit", 64'(o_hit), 64'd1);
        check("coinc_no_step", 64'(o_step), 64'd0);
        check("coinc_array_hit", 64'(o_arr), 64'({20'h001FF, 20'h001FF, 20'h001FE}));
        tick();
        check("coinc_step_late", 64'(o_step), 64'd1);
        check("coinc_array_step", 64'(o_arr), 64'({20'h003FE, 20'h003FE, 20'h003FC}));
        tick();
        check("coinc_step_once", 64'(o_step), 64'd0);
        wait_step(n);
        check("coinc_next_interval", 64'(n), 64'd7);

        // Clear every invader; consecutive hits keep steps deferred
        do_reset();
        do_start();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < 9; c++) begin
                fire(c, r + 2, 1'b1, r);
                tick();
            end
        end
        bv = 1'b0;
        check("cleared_flag", 64'(o_cleared), 64'd1);
        check("cleared_array", 64'(o_arr), 64'd0);
        s0 = steps;
        repeat (50) tick();
        check("cleared_no_steps", 64'(steps - s0), 64'd0);
        check("cleared_sticky", 64'(o_cleared), 64'd1);
        check("cleared_not_landed", 64'(o_landed), 64'd0);
        check("cleared_array_hold", 64'(o_arr), 64'd0);

        // Descend to landing line
        do_reset();
        do_start();
        s0 = steps;
        n = 0;
        while (!o_landed && n < 3000) begin
            tick();
            n++;
        end
        check("landed_flag", 64'(o_landed), 64'd1);
        check("landed_steps", 64'(steps - s0), 64'd120);
        check("landed_step_pulse", 64'(o_step), 64'd1);
        check("landed_line", 64'(o_line), 64'd11);
        check("landed_array", 64'(o_arr), 64'(INIT_ARR));
        s0 = steps;
        repeat (50) tick();
        check("landed_frozen_steps", 64'(steps - s0), 64'd0);
        check("landed_frozen_line", 64'(o_line), 64'd11);
        check("landed_sticky", 64'(o_landed), 64'd1);

        // Reset exits the terminal state
        do_reset();
        check("rst2_landed", 64'(o_landed), 64'd0);
        check("rst2_line", 64'(o_line), 64'd1);
        check("rst2_array", 64'(o_arr), 64'(INIT_ARR));
        s0 = steps;
        repeat (50) tick();
        check("rst2_idle_no_steps", 64'(steps - s0), 64'd0);
        check("final_scoreboard", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
